parity_check_rx: RTL and testbench
==================================

// Module: parity_check_rx
// PURPOSE
//   Serial parity checker/deserialiser: receiving end of the serial parity-generator link.
//   Collects DATA_W data bits (LSB first) followed by one parity bit per frame.
//   Presents the word, a parity-error flag and a saturating error count.
//   Sits between the serial line and word-level consumers.
// PARAMETERS
//   DATA_W     8   data bits per frame (>=2)
//   ODD        0   0 = even parity expected (XOR of data+parity = 0), 1 = odd parity (=1)
//   ERR_CNT_W  8   width of saturating parity-error counter
// PORTS
//   clk          in   1          rising-edge clock
//   reset        in   1          asynchronous, active-high reset
//   in_valid     in   1          qualifies in; a bit is consumed only on edges with in_valid=1
//   in           in   1          serial bit
//   clear        in   1          sync abort: drop partial frame, keep err_count
//   data_out     out  DATA_W     last completed data word
//   out_valid    out  1          one-cycle pulse: frame completed
//   parity_err   out  1          valid with out_valid; held until next frame completes
//   running_par  out  1          XOR of data bits accepted so far in current frame
//   busy         out  1          1 while a frame is partially received
//   err_count    out  ERR_CNT_W  number of parity errors, saturates at all-ones
// BEHAVIOUR
//   - Reset (async, any time, incl. mid-frame): state=S_DATA, bit_cnt=0, shift reg=0,
//     data_out=0, out_valid=0, parity_err=0, running_par=0, busy=0, err_count=0.
//   - FSM: S_DATA --(in_valid && bit_cnt==DATA_W-1)--> S_PAR --(in_valid)--> S_DATA.
//   - S_DATA, in_valid=1: shift reg <= {in, sr[DATA_W-1:1]} (LSB first), running_par ^= in,
//     bit_cnt++; busy=1 from the edge after first bit until frame ends.
//   - S_PAR, in_valid=1: same edge registers data_out <= sr,
//     parity_err <= (running_par ^ in) != ODD, out_valid <= 1, err_count++ if error
//     and not saturated; bit_cnt, running_par, busy cleared.
//   - Latency: out_valid high in cycle after the edge that samples the parity bit.
//   - out_valid is a single-cycle pulse; a new frame may begin on that same cycle
//     (back-to-back frames, no idle bit required).
//   - in_valid=0: no state change except out_valid returns to 0; gaps of any length
//     legal mid-frame.
//   - clear=1 (priority over in_valid): state=S_DATA, bit_cnt=0, running_par=0, busy=0,
//     sr=0; data_out, parity_err, err_count unchanged; out_valid=0 next cycle even if
//     a parity bit was presented on that edge (bit discarded).
//   - err_count at all-ones stays all-ones; only reset clears it.
//   - No output depends combinationally on inputs; all outputs registered.
// TESTING
//   1. DATA_W=8,ODD=0: bits 1,0,1,0,0,1,0,1 (0xA5) then parity 0 -> data_out=8'hA5,
//      out_valid pulse 1 cycle, parity_err=0, err_count=0.
//   2. Same data, parity 1 -> parity_err=1, err_count=1; ODD=1 build, parity 1 -> err=0.
//   3. 0xA5 with in_valid low 3 cycles between each bit -> identical result to test 1,
//      busy=1 throughout gaps, running_par tracks (ends 0).
//   4. Two frames back-to-back (0xA5/p0 then 0x01/p1) -> two pulses, data 0xA5 then 0x01,
//      both parity_err=0.
//   5. 4 bits then clear=1, then full 0x3C/p0 -> data_out=8'h3C, no error; same with
//      async reset mid-frame -> all outputs 0 immediately, next frame decodes cleanly.
//   6. ERR_CNT_W=2: 5 bad-parity frames -> err_count 1,2,3,3,3.

Source files
------------

// File: rtl/parity_check_rx.sv
// parity_check_rx
//   Receiving end of a serial parity-protected link. Shifts in DATA_W data bits
//   (LSB first) followed by one parity bit, then presents the assembled word, a
//   parity-error flag and a saturating count of parity errors.
//
// Parameters
//   DATA_W     data bits per frame (>= 2)
//   ODD        0: even parity expected (XOR of data and parity = 0), 1: odd parity
//   ERR_CNT_W  width of the saturating parity-error counter
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous active-high reset
//   in_valid_i     qualifies in_i; a bit is consumed only when high
//   in_i           serial bit
//   clear_i        synchronous abort of the partial frame (err_count_o kept)
//   data_out_o     last completed data word
//   out_valid_o    one-cycle pulse when a frame completes
//   parity_err_o   parity result of the last completed frame
//   running_par_o  XOR of data bits accepted so far in the current frame
//   busy_o         high while a frame is partially received
//   err_count_o    number of parity errors, saturating at all-ones

module parity_check_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ODD       = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 in_valid_i,
  input  logic                 in_i,
  input  logic                 clear_i,
  output logic [DATA_W-1:0]    data_out_o,
  output logic                 out_valid_o,
  output logic                 parity_err_o,
  output logic                 running_par_o,
  output logic                 busy_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int unsigned CntW = $clog2(DATA_W);

  localparam logic [0:0] StData = 1'b0;
  localparam logic [0:0] StPar  = 1'b1;

  localparam logic [CntW-1:0]      LastBit = CntW'(DATA_W - 1);
  localparam logic                 OddPar  = (ODD != 0);
  localparam logic [ERR_CNT_W-1:0] ErrMax  = {ERR_CNT_W{1'b1}};

  logic [0:0]           state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    sr_q, sr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 perr_q, perr_d;
  logic                 rpar_q, rpar_d;
  logic                 busy_q, busy_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 frame_err;

  // Parity of the whole frame differs from the configured sense.
  assign frame_err = ((rpar_q ^ in_i) != OddPar);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    perr_d      = perr_q;
    rpar_d      = rpar_q;
    busy_d      = busy_q;
    err_cnt_d   = err_cnt_q;

    if (clear_i) begin
      // Abort wins over a bit presented on the same edge, including a parity bit.
      state_d   = StData;
      bit_cnt_d = '0;
      sr_d      = '0;
      rpar_d    = 1'b0;
      busy_d    = 1'b0;
    end else if (in_valid_i) begin
      unique case (state_q)
        StData: begin
          sr_d   = {in_i, sr_q[DATA_W-1:1]};
          rpar_d = rpar_q ^ in_i;
          busy_d = 1'b1;
          if (bit_cnt_q == LastBit) begin
            state_d   = StPar;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StPar: begin
          data_d      = sr_q;
          perr_d      = frame_err;
          out_valid_d = 1'b1;
          if (frame_err && (err_cnt_q != ErrMax)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          state_d   = StData;
          bit_cnt_d = '0;
          rpar_d    = 1'b0;
          busy_d    = 1'b0;
        end
        default: state_d = StData;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StData;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      perr_q      <= 1'b0;
      rpar_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      perr_q      <= perr_d;
      rpar_q      <= rpar_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data_out_o    = data_q;
  assign out_valid_o   = out_valid_q;
  assign parity_err_o  = perr_q;
  assign running_par_o = rpar_q;
  assign busy_o        = busy_q;
  assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_parity_check_rx.sv
// Bench for parity_check_rx: three instances (even parity, odd parity, 2-bit
// error counter) share clock, reset and the serial bit; sel routes in_valid and
// clear to one instance at a time.

module tb_parity_check_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       iv = 1'b0;
  logic       ser = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] sel = 2'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic [7:0] e_data, o_data, s_data;
  logic       e_ov, e_pe, e_rp, e_busy;
  logic       o_ov, o_pe, o_rp, o_busy;
  logic       s_ov, s_pe, s_rp, s_busy;
  logic [7:0] e_err, o_err;
  logic [1:0] s_err;

  parity_check_rx #(.DATA_W(8), .ODD(0), .ERR_CNT_W(8)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(iv && (sel == 2'd0)), .in_i(ser),
    .clear_i(clr && (sel == 2'd0)), .data_out_o(e_data), .out_valid_o(e_ov),
    .parity_err_o(e_pe), .running_par_o(e_rp), .busy_o(e_busy), .err_count_o(e_err)
  );

  parity_check_rx #(.DATA_W(8), .ODD(1), .ERR_CNT_W(8)) dut_odd (
    .clk_i(clk), .reset_i(reset), .in_valid_i(iv && (sel == 2'd1)), .in_i(ser),
    .clear_i(clr && (sel == 2'd1)), .data_out_o(o_data), .out_valid_o(o_ov),
    .parity_err_o(o_pe), .running_par_o(o_rp), .busy_o(o_busy), .err_count_o(o_err)
  );

  parity_check_rx #(.DATA_W(8), .ODD(0), .ERR_CNT_W(2)) dut_sat (
    .clk_i(clk), .reset_i(reset), .in_valid_i(iv && (sel == 2'd2)), .in_i(ser),
    .clear_i(clr && (sel == 2'd2)), .data_out_o(s_data), .out_valid_o(s_ov),
    .parity_err_o(s_pe), .running_par_o(s_rp), .busy_o(s_busy), .err_count_o(s_err)
  );

  // All tasks start and end just after a falling edge.
  task automatic drive_bit(input logic b);
    iv  = 1'b1;
    ser = b;
    @(negedge clk);
  endtask

  task automatic drive_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
  endtask

  task automatic idle(input int n);
    iv = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({e_data, e_ov, e_pe, e_rp, e_busy, e_err} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state got data=%h ov=%b pe=%b rp=%b busy=%b err=%0d want all 0",
               e_data, e_ov, e_pe, e_rp, e_busy, e_err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame;
    sel = 2'd0;
    drive_bit(1'b1);
    checks++;
    if (e_busy !== 1'b1 || e_rp !== 1'b1) begin
      failures++;
      $display("FAIL first_bit busy=%b rp=%b want 1 1", e_busy, e_rp);
    end
    for (int i = 1; i < 8; i++) drive_bit(8'hA5 >> i);
    drive_bit(1'b0);
    iv = 1'b0;
    checks++;
    if (e_ov !== 1'b1 || e_data !== 8'hA5 || e_pe !== 1'b0 || e_err !== 8'd0 ||
        e_busy !== 1'b0) begin
      failures++;
      $display("FAIL good_frame ov=%b data=%h pe=%b err=%0d busy=%b want 1 a5 0 0 0",
               e_ov, e_data, e_pe, e_err, e_busy);
    end
    idle(1);
    checks++;
    if (e_ov !== 1'b0 || e_data !== 8'hA5) begin
      failures++;
      $display("FAIL pulse_width ov=%b data=%h want 0 a5", e_ov, e_data);
    end
  endtask

  task automatic test_bad_parity;
    sel = 2'd0;
    drive_data(8'hA5);
    drive_bit(1'b1);
    iv = 1'b0;
    checks++;
    if (e_ov !== 1'b1 || e_pe !== 1'b1 || e_err !== 8'd1) begin
      failures++;
      $display("FAIL bad_parity ov=%b pe=%b err=%0d want 1 1 1", e_ov, e_pe, e_err);
    end
    idle(2);
    checks++;
    if (e_pe !== 1'b1 || e_err !== 8'd1) begin
      failures++;
      $display("FAIL perr_hold pe=%b err=%0d want 1 1", e_pe, e_err);
    end
    sel = 2'd1;
    drive_data(8'hA5);
    drive_bit(1'b1);
    iv = 1'b0;
    checks++;
    if (o_ov !== 1'b1 || o_pe !== 1'b0 || o_err !== 8'd0 || o_data !== 8'hA5) begin
      failures++;
      $display("FAIL odd_good ov=%b pe=%b err=%0d data=%h want 1 0 0 a5",
               o_ov, o_pe, o_err, o_data);
    end
    idle(1);
    drive_data(8'hA5);
    drive_bit(1'b0);
    iv = 1'b0;
    checks++;
    if (o_pe !== 1'b1 || o_err !== 8'd1) begin
      failures++;
      $display("FAIL odd_bad pe=%b err=%0d want 1 1", o_pe, o_err);
    end
    idle(1);
  endtask

  task automatic test_gaps;
    logic exp_rp;
    logic [7:0] d;
    sel = 2'd0;
    d = 8'hA5;
    exp_rp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_bit(d[i]);
      exp_rp = exp_rp ^ d[i];
      idle(3);
      checks++;
      if (e_busy !== 1'b1 || e_rp !== exp_rp) begin
        failures++;
        $display("FAIL gap_bit%0d busy=%b rp=%b want 1 %b", i, e_busy, e_rp, exp_rp);
      end
    end
    drive_bit(1'b0);
    iv = 1'b0;
    checks++;
    if (e_ov !== 1'b1 || e_data !== 8'hA5 || e_pe !== 1'b0 || e_err !== 8'd1) begin
      failures++;
      $display("FAIL gap_frame ov=%b data=%h pe=%b err=%0d want 1 a5 0 1",
               e_ov, e_data, e_pe, e_err);
    end
    idle(1);
  endtask

  task automatic test_back_to_back;
    sel = 2'd0;
    drive_data(8'hA5);
    drive_bit(1'b0);
    checks++;
    if (e_ov !== 1'b1 || e_data !== 8'hA5 || e_pe !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first ov=%b data=%h pe=%b want 1 a5 0", e_ov, e_data, e_pe);
    end
    drive_bit(1'b1);
    checks++;
    if (e_ov !== 1'b0 || e_busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_gap ov=%b busy=%b want 0 1", e_ov, e_busy);
    end
    for (int i = 1; i < 8; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    iv = 1'b0;
    checks++;
    if (e_ov !== 1'b1 || e_data !== 8'h01 || e_pe !== 1'b0 || e_err !== 8'd1) begin
      failures++;
      $display("FAIL b2b_second ov=%b data=%h pe=%b err=%0d want 1 01 0 1",
               e_ov, e_data, e_pe, e_err);
    end
    idle(1);
  endtask

  task automatic test_clear_and_reset;
    sel = 2'd0;
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    clr = 1'b1;
    drive_bit(1'b1);
    clr = 1'b0;
    iv  = 1'b0;
    checks++;
    if (e_busy !== 1'b0 || e_rp !== 1'b0 || e_ov !== 1'b0 || e_data !== 8'h01) begin
      failures++;
      $display("FAIL clear_mid busy=%b rp=%b ov=%b data=%h want 0 0 0 01",
               e_busy, e_rp, e_ov, e_data);
    end
    drive_data(8'h3C);
    drive_bit(1'b0);
    iv = 1'b0;
    checks++;
    if (e_ov !== 1'b1 || e_data !== 8'h3C || e_pe !== 1'b0 || e_err !== 8'd1) begin
      failures++;
      $display("FAIL after_clear ov=%b data=%h pe=%b err=%0d want 1 3c 0 1",
               e_ov, e_data, e_pe, e_err);
    end
    idle(1);
    // Clear on the parity edge discards the frame; bad parity must not count.
    drive_data(8'hFF);
    clr = 1'b1;
    drive_bit(1'b1);
    clr = 1'b0;
    iv  = 1'b0;
    checks++;
    if (e_ov !== 1'b0 || e_data !== 8'h3C || e_err !== 8'd1 || e_busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_parity ov=%b data=%h err=%0d busy=%b want 0 3c 1 0",
               e_ov, e_data, e_err, e_busy);
    end
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    iv = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({e_data, e_ov, e_pe, e_rp, e_busy, e_err} !== 20'h0) begin
      failures++;
      $display("FAIL async_reset data=%h ov=%b pe=%b rp=%b busy=%b err=%0d want all 0",
               e_data, e_ov, e_pe, e_rp, e_busy, e_err);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive_data(8'hA5);
    drive_bit(1'b0);
    iv = 1'b0;
    checks++;
    if (e_ov !== 1'b1 || e_data !== 8'hA5 || e_pe !== 1'b0 || e_err !== 8'd0) begin
      failures++;
      $display("FAIL after_reset ov=%b data=%h pe=%b err=%0d want 1 a5 0 0",
               e_ov, e_data, e_pe, e_err);
    end
    idle(1);
  endtask

  task automatic test_saturation;
    logic [1:0] exp_err [5];
    exp_err = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sel = 2'd2;
    for (int f = 0; f < 5; f++) begin
      drive_data(8'hA5);
      drive_bit(1'b1);
      iv = 1'b0;
      checks++;
      if (s_ov !== 1'b1 || s_pe !== 1'b1 || s_err !== exp_err[f]) begin
        failures++;
        $display("FAIL sat_frame%0d ov=%b pe=%b err=%0d want 1 1 %0d",
                 f, s_ov, s_pe, s_err, exp_err[f]);
      end
      idle(1);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_gaps();
    test_back_to_back();
    test_clear_and_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
